// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 display timing constants and coordinate type.
// Used by the sync generator, the pixel renderer and the game logic.
package vga_sync_gen_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam bit VGA_SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: pix_en in, coordinates/syncs/strobes out.
// master = timing generator, slave = renderer / game logic side.
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  logic   pix_en;
  coord_t hc;
  coord_t vc;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   line_tick;
  logic   frame_tick;

  modport master (
    input  pix_en,
    output hc, vc, hsync, vsync,
    output video_on, line_tick, frame_tick
  );

  modport slave (
    output pix_en,
    input  hc, vc, hsync, vsync,
    input  video_on, line_tick, frame_tick
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with registered sync/active decodes.
// Ports: clk, rst (sync, active-low), step in; count, count_nxt, wrap, sync_n, active out.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter coord_t TOTAL      = coord_t'(VGA_H_TOTAL),
  parameter coord_t SYNC_START = coord_t'(VGA_H_VISIBLE + VGA_H_FRONT),
  parameter coord_t SYNC_END   = coord_t'(VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC),
  parameter coord_t VISIBLE    = coord_t'(VGA_H_VISIBLE)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  output coord_t count,
  output coord_t count_nxt,
  output logic   wrap,
  output logic   sync_n,
  output logic   active
);

  localparam coord_t LAST = TOTAL - coord_t'(1);

  assign wrap = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (step) begin
      count_nxt = wrap ? '0 : count + coord_t'(1);
    end
  end

  // Decodes come from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= '0;
      sync_n <= 1'b1;
      active <= 1'b1;
    end else if (step) begin
      count  <= count_nxt;
      sync_n <= !((count_nxt >= SYNC_START) && (count_nxt < SYNC_END));
      active <= (count_nxt < VISIBLE);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator, advanced by a pixel-enable strobe.
// Ports: clk, rst (sync, active-low); bus (master): pix_en in, hc/vc/syncs/video_on/ticks out.
module vga_sync_gen
#(
  parameter int unsigned H_VISIBLE   = vga_sync_gen_pkg::VGA_H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_sync_gen_pkg::VGA_H_FRONT,
  parameter int unsigned H_SYNC      = vga_sync_gen_pkg::VGA_H_SYNC,
  parameter int unsigned H_BACK      = vga_sync_gen_pkg::VGA_H_BACK,
  parameter int unsigned V_VISIBLE   = vga_sync_gen_pkg::VGA_V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_sync_gen_pkg::VGA_V_FRONT,
  parameter int unsigned V_SYNC      = vga_sync_gen_pkg::VGA_V_SYNC,
  parameter int unsigned V_BACK      = vga_sync_gen_pkg::VGA_V_BACK,
  parameter bit          SYNC_ACTIVE = vga_sync_gen_pkg::VGA_SYNC_ACTIVE
) (
  input logic           clk,
  input logic           rst,
  vga_sync_gen_if.master bus
);
  import vga_sync_gen_pkg::*;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  coord_t h_cnt, h_nxt, v_cnt, v_nxt;
  logic   h_wrap, v_wrap;
  logic   h_sync_n, v_sync_n;
  logic   h_act, v_act;
  logic   v_step;
  logic   unused_nxt;

  assign v_step = bus.pix_en && h_wrap;

  vga_axis_counter #(
    .TOTAL      (coord_t'(H_TOTAL)),
    .SYNC_START (coord_t'(H_VISIBLE + H_FRONT)),
    .SYNC_END   (coord_t'(H_VISIBLE + H_FRONT + H_SYNC)),
    .VISIBLE    (coord_t'(H_VISIBLE))
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .step      (bus.pix_en),
    .count     (h_cnt),
    .count_nxt (h_nxt),
    .wrap      (h_wrap),
    .sync_n    (h_sync_n),
    .active    (h_act)
  );

  vga_axis_counter #(
    .TOTAL      (coord_t'(V_TOTAL)),
    .SYNC_START (coord_t'(V_VISIBLE + V_FRONT)),
    .SYNC_END   (coord_t'(V_VISIBLE + V_FRONT + V_SYNC)),
    .VISIBLE    (coord_t'(V_VISIBLE))
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .step      (v_step),
    .count     (v_cnt),
    .count_nxt (v_nxt),
    .wrap      (v_wrap),
    .sync_n    (v_sync_n),
    .active    (v_act)
  );

  assign unused_nxt = ^{h_nxt, v_nxt};

  assign bus.hc       = h_cnt;
  assign bus.vc       = v_cnt;
  assign bus.hsync    = h_sync_n ^ SYNC_ACTIVE;
  assign bus.vsync    = v_sync_n ^ SYNC_ACTIVE;
  assign bus.video_on = h_act && v_act;

  // Strobes are held off while reset is asserted.
  assign bus.line_tick  = rst && v_step;
  assign bus.frame_tick = rst && v_step && v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: full-size instance for the line,
// reduced-timing instance (16x12 raster) for vertical and frame behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  vga_sync_gen_if b0 ();
  vga_sync_gen_if b1 ();
  assign b0.pix_en = en;
  assign b1.pix_en = en;

  vga_sync_gen d0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.master)
  );

  // H: 8+2+3+3=16, sync hc 10..12. V: 6+2+2+2=12, sync vc 8..9.
  vga_sync_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
    .SYNC_ACTIVE (1'b0)
  ) d1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.master)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [24:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   meas = 0;
  int   nft = 0;
  int   nlines = 0;
  int   last_ft = 0;
  bit   done = 0;

  always @(posedge clk) cyc++;

  task automatic drive(input bit p, input bit r);
    @(posedge clk);
    #1;
    en  = p;
    rst = r;
  endtask

  task automatic pix(input int n);
    repeat (n) begin
      drive(1'b1, 1'b1);
      repeat (3) drive(1'b0, 1'b1);
    end
  endtask

  task automatic push(input string n, input bit sel,
                      input int hc, input int vc,
                      input bit hs, input bit vs, input bit von,
                      input bit lt, input bit ft);
    exp_t x;
    x.name = n;
    x.sel  = sel;
    x.v    = {hc[9:0], vc[9:0], hs, vs, von, lt, ft};
    q.push_back(x);
  endtask

  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s got %0d need %0d", n, a, x);
    end
  endtask

  function automatic logic [24:0] act(input bit sel);
    if (sel)
      return {b1.hc, b1.vc, b1.hsync, b1.vsync,
              b1.video_on, b1.line_tick, b1.frame_tick};
    return {b0.hc, b0.vc, b0.hsync, b0.vsync,
            b0.video_on, b0.line_tick, b0.frame_tick};
  endfunction

  // Monitor: compare every pending expectation mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      logic [24:0] a;
      e = q.pop_front();
      a = act(e.sel);
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s dut%0d got hc=%0d vc=%0d hs,vs,von,lt,ft=%b need hc=%0d vc=%0d hs,vs,von,lt,ft=%b",
                 e.name, e.sel, a[24:15], a[14:5], a[4:0],
                 e.v[24:15], e.v[14:5], e.v[4:0]);
      end
    end
  end

  // Frame period / line count on the reduced instance: 192 enables x 4 clk.
  always @(negedge clk) begin
    if (meas) begin
      if (b1.line_tick) nlines++;
      if (b1.frame_tick) begin
        if (nft > 0) begin
          chk("frame_period", cyc - last_ft, 768);
          chk("frame_lines", nlines, 12);
        end
        nft++;
        last_ft = cyc;
        nlines  = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog got timeout need finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    en  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(i % 2 == 0, 1'b0);
    push("rst", 0, 0, 0, 1, 1, 1, 0, 0);
    push("rst", 1, 0, 0, 1, 1, 1, 0, 0);
    drive(1'b0, 1'b1);
    push("rel", 0, 0, 0, 1, 1, 1, 0, 0);
    push("rel", 1, 0, 0, 1, 1, 1, 0, 0);
    drive(1'b1, 1'b1);
    push("hold", 0, 0, 0, 1, 1, 1, 0, 0);
    drive(1'b0, 1'b1);
    push("first", 0, 1, 0, 1, 1, 1, 0, 0);
    push("first", 1, 1, 0, 1, 1, 1, 0, 0);

    pix(99);
    push("frz", 0, 100, 0, 1, 1, 1, 0, 0);
    repeat (4) begin
      repeat (25) drive(1'b0, 1'b1);
      push("frz", 0, 100, 0, 1, 1, 1, 0, 0);
    end
    pix(1);
    push("resume", 0, 101, 0, 1, 1, 1, 0, 0);

    pix(538);
    push("h639", 0, 639, 0, 1, 1, 1, 0, 0);
    pix(1);
    push("h640", 0, 640, 0, 1, 1, 0, 0, 0);
    pix(15);
    push("h655", 0, 655, 0, 1, 1, 0, 0, 0);
    pix(1);
    push("h656", 0, 656, 0, 0, 1, 0, 0, 0);
    pix(95);
    push("h751", 0, 751, 0, 0, 1, 0, 0, 0);
    pix(1);
    push("h752", 0, 752, 0, 1, 1, 0, 0, 0);
    pix(47);
    push("h799", 0, 799, 0, 1, 1, 0, 0, 0);
    drive(1'b1, 1'b1);
    push("ltick", 0, 799, 0, 1, 1, 0, 1, 0);
    drive(1'b0, 1'b1);
    push("hwrap", 0, 0, 1, 1, 1, 1, 0, 0);

    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    push("rst2", 0, 0, 0, 1, 1, 1, 0, 0);
    push("rst2", 1, 0, 0, 1, 1, 1, 0, 0);

    pix(11);
    push("s_hs", 1, 11, 0, 0, 1, 0, 0, 0);
    pix(69);
    push("s_v5", 1, 0, 5, 1, 1, 1, 0, 0);
    pix(16);
    push("s_v6", 1, 0, 6, 1, 1, 0, 0, 0);
    pix(31);
    push("s_v7", 1, 15, 7, 1, 1, 0, 0, 0);
    pix(1);
    push("s_v8", 1, 0, 8, 1, 0, 0, 0, 0);
    pix(31);
    push("s_v9", 1, 15, 9, 1, 0, 0, 0, 0);
    pix(1);
    push("s_v10", 1, 0, 10, 1, 1, 0, 0, 0);
    pix(31);
    push("s_last", 1, 15, 11, 1, 1, 0, 0, 0);
    drive(1'b1, 1'b1);
    push("s_ft", 1, 15, 11, 1, 1, 0, 1, 1);
    drive(1'b0, 1'b1);
    push("s_wrap", 1, 0, 0, 1, 1, 1, 0, 0);

    meas = 1'b1;
    pix(576);
    meas = 1'b0;
    chk("frame_count", nft, 3);

    pix(155);
    push("s_mid", 1, 11, 9, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0);
    push("s_rstcyc", 1, 11, 9, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1);
    push("s_midrst", 1, 0, 0, 1, 1, 1, 0, 0);
    push("midrst", 0, 0, 0, 1, 1, 1, 0, 0);
    pix(191);
    push("s_full", 1, 15, 11, 1, 1, 0, 0, 0);
    drive(1'b1, 1'b1);
    push("s_full_ft", 1, 15, 11, 1, 1, 0, 1, 1);
    drive(1'b0, 1'b1);
    push("s_full_wrap", 1, 0, 0, 1, 1, 1, 0, 0);

    repeat (3) drive(1'b0, 1'b1);
    chk("drain", q.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480@60 Hz display path, directly downstream of the clock divider. It consumes the 25 MHz pixel-enable strobe and advances horizontal/vertical pixel counters once per enabled cycle. It produces registered hsync/vsync for the VGA pins, plus pixel coordinates, a video-active flag and line/frame strobes for the pixel renderer and game logic. Everything runs in the 100 MHz domain; pix_en is a clock enable, never a clock.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse

Ports:
- clk  in  1  master clock, 100 MHz
- rst  in  1  synchronous reset, active-low; sampled on rising clk
- pix_en  in  1  pixel enable, one clk cycle high every 4 cycles
- hc  out  10  horizontal pixel counter, 0..H_TOTAL-1
- vc  out  10  vertical line counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync to pin
- vsync  out  1  vertical sync to pin
- video_on  out  1  high when (hc, vc) is in the visible area
- line_tick  out  1  one-clk pulse on the last pixel of every line
- frame_tick  out  1  one-clk pulse on the last pixel of every frame

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- All state advances only on a rising clk with rst=1 and pix_en=1. When pix_en=0, every output holds.
- hc steps +1 per enable. When hc=H_TOTAL-1, hc wraps to 0 and vc steps +1. When vc=V_TOTAL-1 and hc=H_TOTAL-1, both wrap to 0.
- hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751). Otherwise it is the inverse.
- vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491). Otherwise it is the inverse.
- video_on = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- line_tick = pix_en && hc==H_TOTAL-1. frame_tick = line_tick && vc==V_TOTAL-1. Both are combinational from registered state and pix_en, so each lasts exactly one clk.
- Counter widths are unsigned 10 bits. Comparisons are unsigned. The wrap is explicit, never by overflow.

## Timing
- hsync, vsync and video_on are registers. They are computed from the next-state hc/vc and load on the same edge as the counters, so all of hc, vc, hsync, vsync and video_on describe the same pixel. There is zero latency between the coordinate and its decodes.
- Reset (rst=0 at an edge) sets: hc=0, vc=0, hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE, video_on=1. line_tick and frame_tick are 0 while rst=0.
- Reset wins over pix_en when both are asserted in the same cycle.
- Reset in mid-frame restarts at (0,0) on the next edge. No partial sync pulse is stretched; the pins return to the inactive level immediately.
- Steady state: line period is 3200 clk, frame period is 1,680,000 clk, and hsync is active for 384 clk.

## Structure
- The shared display package holds the 640x480 timing constants (visible, front, sync, back for both axes), the derived totals, and the 10-bit coordinate typedef. The renderer and the game logic use the same package.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). It takes the parameters TOTAL, SYNC_START, SYNC_END and VISIBLE, and has inputs clk, rst and step. Its outputs are the count, the next count, wrap, sync_n and active. The vertical instance's step is the horizontal wrap qualified with pix_en.

## Test plan
- Reset: hold rst=0 for 5 clk with pix_en toggling, then release -> hc=0, vc=0, hsync=vsync=1, video_on=1, no ticks. The first pix_en after release gives hc=1.
- pix_en stuck low for 100 clk in mid-line -> all outputs frozen. Resuming continues from the held hc with no skip.
- Horizontal sweep: hc reaches 655 -> hsync=1; hc=656 -> hsync=0; hc=751 -> hsync=0; hc=752 -> hsync=1. At hc=799 line_tick pulses once, then hc=0 and vc increments. video_on drops at hc=640.
- Vertical: vsync=0 exactly for vc=490..491 (3200 clk × 2). video_on=0 for all vc>=480. frame_tick pulses at (799,524), then (0,0) follows.
- Frame period: measure 3 consecutive frame_tick pulses -> exactly 1,680,000 clk apart, and exactly 525 line_ticks between them.
- Reset mid-operation with rst=0 at hc=700, vc=491 (during vsync and hsync) -> on the next edge hc=vc=0 and both sync pins are inactive. The following frame is full length.
